// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch / program-counter stage of the multicycle MIPS core.
// Holds the PC and requests instructions over an imemREN/ihit handshake.
// It latches the fetched word and presents it to decode until the datapath
// reports completion via advance. It then loads the next PC, which is chosen
// from PCsrc (sequential, JR, J/JAL, BNE, BEQ).
//
// Ports
//   CLK, RST      core clock; synchronous active-high reset
//   ihit          icache: imemload valid for imemaddr this cycle
//   imemload      icache read data
//   imemREN       instruction read request (FETCH only)
//   imemaddr      instruction address, always equal to pc
//   instr         latched instruction for the control unit
//   instr_valid   instr is the instruction under execution (EXEC only)
//   pc, npc       current PC and pc+4 (JAL link value)
//   PCsrc         next-PC select from the control unit
//   addr          J/JAL target field
//   imm           branch offset
//   zero          ALU zero flag from the rs - rt compare
//   rdat1         rs value, used as the JR target
//   advance       current instruction has completed
//   halt          HALT decoded
//   halted        core stopped; sticky until reset
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] npc,
    input  logic [2:0]  PCsrc,
    input  logic [25:0] addr,
    input  logic [15:0] imm,
    input  logic        zero,
    input  logic [31:0] rdat1,
    input  logic        advance,
    input  logic        halt,
    output logic        halted
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [2:0] SRC_SEQ = 3'd0;
    localparam logic [2:0] SRC_JR  = 3'd2;
    localparam logic [2:0] SRC_J   = 3'd3;
    localparam logic [2:0] SRC_BNE = 3'd4;
    localparam logic [2:0] SRC_BEQ = 3'd5;

    // The reset PC is word aligned just like every other loaded PC.
    localparam logic [31:0] PC_RESET = {PC_INIT[31:2], 2'b00};

    logic [1:0]  state_r;
    logic [31:0] pc_r;
    logic [31:0] npc_r;
    logic [31:0] instr_r;
    logic        imem_ren_r;
    logic        instr_valid_r;
    logic        halted_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] imm_sext_s;
    logic [31:0] branch_s;
    logic [31:0] target_s;
    logic [31:0] next_pc_s;

    // Next-PC selection; it is only sampled on the EXEC -> FETCH edge.
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
        imm_sext_s = {{16{imm[15]}}, imm};
        branch_s   = pc_plus4_s + {imm_sext_s[29:0], 2'b00};
        target_s   = pc_plus4_s;
        case (PCsrc)
            SRC_SEQ: target_s = pc_plus4_s;
            SRC_JR:  target_s = rdat1;
            SRC_J:   target_s = {pc_plus4_s[31:28], addr, 2'b00};
            SRC_BNE: target_s = zero ? pc_plus4_s : branch_s;
            SRC_BEQ: target_s = zero ? branch_s : pc_plus4_s;
            default: target_s = pc_plus4_s;
        endcase
        next_pc_s = {target_s[31:2], 2'b00};
    end

    // Fetch/execute/halt sequencing. The status flags are registered together
    // with the state, so no output has a combinational path from an input.
    // npc tracks pc + 4 as its own register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= FETCH;
            pc_r          <= PC_RESET;
            npc_r         <= PC_RESET + 32'd4;
            instr_r       <= 32'd0;
            imem_ren_r    <= 1'b1;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (ihit) begin
                        instr_r       <= imemload;
                        state_r       <= EXEC;
                        imem_ren_r    <= 1'b0;
                        instr_valid_r <= 1'b1;
                    end else begin
                        state_r       <= FETCH;
                    end
                end
                EXEC: begin
                    // halt wins over a simultaneous advance; pc is kept.
                    if (halt) begin
                        state_r       <= HALTED;
                        instr_valid_r <= 1'b0;
                        halted_r      <= 1'b1;
                    end else if (advance) begin
                        pc_r          <= next_pc_s;
                        npc_r         <= next_pc_s + 32'd4;
                        state_r       <= FETCH;
                        imem_ren_r    <= 1'b1;
                        instr_valid_r <= 1'b0;
                    end else begin
                        state_r       <= EXEC;
                    end
                end
                HALTED: begin
                    state_r <= HALTED;
                end
                default: begin
                    // Unreachable encoding: re-fetch at the current PC.
                    state_r       <= FETCH;
                    imem_ren_r    <= 1'b1;
                    instr_valid_r <= 1'b0;
                    halted_r      <= 1'b0;
                end
            endcase
        end
    end

    assign imemREN     = imem_ren_r;
    assign imemaddr    = pc_r;
    assign pc          = pc_r;
    assign npc         = npc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Expected instruction words and expected
// PCs are pushed to queues when the stimulus is driven. They are popped and
// compared when the DUT shows the instruction or enters the next FETCH.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [2:0]  PCsrc;
    logic [25:0] addr;
    logic [15:0] imm;
    logic        zero;
    logic [31:0] rdat1;
    logic        advance;
    logic        halt;
    logic        halted;

    int          n_checks;
    int          n_fail;
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;
    logic [31:0] instr_q[$];
    logic [31:0] pc_q[$];

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .npc(npc), .PCsrc(PCsrc),
        .addr(addr), .imm(imm), .zero(zero), .rdat1(rdat1),
        .advance(advance), .halt(halt), .halted(halted)
    );

    // 10 ns core clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait 'waits' FETCH cycles without ihit, then deliver 'word'.
    task automatic fetch(input logic [31:0] word, input int waits);
        for (int i = 0; i < waits; i++) begin
            ihit     = 1'b0;
            imemload = $urandom;
            tick();
            check_eq("wait_addr", imemaddr, cur_pc);
            check_eq("wait_ren", 32'(imemREN), 32'd1);
            check_eq("wait_valid", 32'(instr_valid), 32'd0);
        end
        ihit     = 1'b1;
        imemload = word;
        instr_q.push_back(word);
        tick();
        ihit     = 1'b0;
        imemload = $urandom;
        if (instr_q.size() == 0) begin
            check_eq("instr_q_empty", 32'd1, 32'd0);
        end else begin
            cur_instr = instr_q.pop_front();
            check_eq("instr", instr, cur_instr);
        end
        check_eq("exec_valid", 32'(instr_valid), 32'd1);
        check_eq("exec_ren", 32'(imemREN), 32'd0);
        check_eq("exec_pc", pc, cur_pc);
    endtask

    // Complete the current instruction with the given next-PC controls.
    task automatic exec_step(input logic [2:0] src, input logic [25:0] a,
                             input logic [15:0] im, input logic z,
                             input logic [31:0] r1, input logic [31:0] exp_pc);
        PCsrc   = src;
        addr    = a;
        imm     = im;
        zero    = z;
        rdat1   = r1;
        advance = 1'b1;
        pc_q.push_back(exp_pc);
        tick();
        advance = 1'b0;
        PCsrc   = 3'd0;
        rdat1   = $urandom;
        if (pc_q.size() == 0) begin
            check_eq("pc_q_empty", 32'd1, 32'd0);
        end else begin
            cur_pc = pc_q.pop_front();
            check_eq("next_pc", pc, cur_pc);
            check_eq("next_addr", imemaddr, cur_pc);
            check_eq("next_npc", npc, cur_pc + 32'd4);
        end
        check_eq("fetch_ren", 32'(imemREN), 32'd1);
        check_eq("fetch_valid", 32'(instr_valid), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pc"}, pc, 32'h0000_0000);
        check_eq({tag, "_addr"}, imemaddr, 32'h0000_0000);
        check_eq({tag, "_npc"}, npc, 32'h0000_0004);
        check_eq({tag, "_instr"}, instr, 32'h0000_0000);
        check_eq({tag, "_ren"}, 32'(imemREN), 32'd1);
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check_eq({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        ihit     = 1'b0;
        imemload = 32'd0;
        PCsrc    = 3'd0;
        addr     = 26'd0;
        imm      = 16'd0;
        zero     = 1'b0;
        rdat1    = 32'd0;
        advance  = 1'b0;
        halt     = 1'b0;
        cur_pc   = 32'd0;

        tick();
        tick();
        check_reset_state("rst");
        RST = 1'b0;

        // Reset/sequential: ihit on the third FETCH cycle.
        fetch(32'h2001_0005, 2);
        exec_step(3'd0, 26'd0, 16'd0, 1'b0, 32'd0, 32'h0000_0004);

        // Unused select codes fall back to pc+4.
        fetch(32'h1111_0001, 0);
        exec_step(3'd6, 26'h3FF_FFFF, 16'h7FFF, 1'b1, 32'hDEAD_BEEF, 32'h0000_0008);

        // BEQ taken / not taken from pc = 0x100.
        fetch(32'h1000_0001, 1);
        exec_step(3'd2, 26'd0, 16'd0, 1'b0, 32'h0000_0100, 32'h0000_0100);
        fetch(32'h1000_FFFE, 0);
        exec_step(3'd5, 26'd0, 16'hFFFE, 1'b1, 32'd0, 32'h0000_00FC);
        fetch(32'h1000_0002, 0);
        exec_step(3'd2, 26'd0, 16'd0, 1'b0, 32'h0000_0100, 32'h0000_0100);
        fetch(32'h1000_FFFE, 0);
        exec_step(3'd5, 26'd0, 16'hFFFE, 1'b0, 32'd0, 32'h0000_0104);

        // BNE gives the inverse results.
        fetch(32'h1400_0003, 0);
        exec_step(3'd2, 26'd0, 16'd0, 1'b0, 32'h0000_0100, 32'h0000_0100);
        fetch(32'h1400_FFFE, 0);
        exec_step(3'd4, 26'd0, 16'hFFFE, 1'b1, 32'd0, 32'h0000_0104);
        fetch(32'h1400_0004, 0);
        exec_step(3'd2, 26'd0, 16'd0, 1'b0, 32'h0000_0100, 32'h0000_0100);
        fetch(32'h1400_FFFE, 0);
        exec_step(3'd4, 26'd0, 16'hFFFE, 1'b0, 32'd0, 32'h0000_00FC);

        // J then JR with a misaligned target.
        fetch(32'h0000_0008, 0);
        exec_step(3'd2, 26'd0, 16'd0, 1'b0, 32'h1000_0040, 32'h1000_0040);
        fetch(32'h0800_0010, 0);
        check_eq("npc_before_j", npc, 32'h1000_0044);
        exec_step(3'd3, 26'h000_0010, 16'd0, 1'b0, 32'd0, 32'h1000_0040);
        fetch(32'h0020_0008, 0);
        exec_step(3'd2, 26'd0, 16'd0, 1'b0, 32'h0000_0123, 32'h0000_0120);

        // Wrap from the top of the address space.
        fetch(32'h0000_0009, 0);
        exec_step(3'd2, 26'd0, 16'd0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch(32'h0000_000A, 0);
        exec_step(3'd0, 26'd0, 16'd0, 1'b0, 32'd0, 32'h0000_0000);

        // Stall: 10 EXEC cycles with ihit/imemload toggling.
        fetch(32'hCAFE_0001, 0);
        for (int i = 0; i < 10; i++) begin
            ihit     = ~ihit;
            imemload = $urandom;
            tick();
            check_eq("stall_instr", instr, cur_instr);
            check_eq("stall_pc", pc, cur_pc);
            check_eq("stall_ren", 32'(imemREN), 32'd0);
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
        end
        ihit = 1'b0;

        // halt beats advance in the same EXEC cycle.
        halt    = 1'b1;
        advance = 1'b1;
        PCsrc   = 3'd2;
        rdat1   = 32'h0000_0400;
        tick();
        halt    = 1'b0;
        advance = 1'b0;
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_pc", pc, cur_pc);
        check_eq("halt_ren", 32'(imemREN), 32'd0);
        check_eq("halt_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            ihit     = i[0];
            advance  = ~i[0];
            imemload = $urandom;
            tick();
            check_eq("halted_sticky", 32'(halted), 32'd1);
            check_eq("halted_pc", pc, cur_pc);
            check_eq("halted_instr", instr, cur_instr);
            check_eq("halted_ren", 32'(imemREN), 32'd0);
        end
        ihit    = 1'b0;
        advance = 1'b0;

        // Reset leaves HALTED.
        RST = 1'b1;
        tick();
        RST    = 1'b0;
        cur_pc = 32'd0;
        check_reset_state("rst_halt");

        // Reset during FETCH with ihit high.
        fetch(32'hABCD_0001, 0);
        exec_step(3'd2, 26'd0, 16'd0, 1'b0, 32'h0000_0200, 32'h0000_0200);
        ihit     = 1'b1;
        imemload = 32'h5555_AAAA;
        RST      = 1'b1;
        tick();
        RST    = 1'b0;
        ihit   = 1'b0;
        cur_pc = 32'd0;
        check_reset_state("rst_fetch");

        // Normal operation resumes after reset.
        fetch(32'h2002_0007, 1);
        exec_step(3'd0, 26'd0, 16'd0, 1'b0, 32'd0, 32'h0000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and program-counter stage of the multicycle MIPS core, directly upstream of the control unit. Holds the PC and requests instructions from the instruction cache with an `imemREN`/`ihit` handshake. Latches the fetched word and presents it to decode until the datapath signals completion. Computes the next PC from the control unit's `PCsrc`, jump `addr`, branch `imm`, ALU `zero` and register `rdat1` (JR).

## Interface
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `CLK`  in  1  core clock; all state updates on rising edge.
- `RST`  in  1  **reset, synchronous, active-high.**
- `ihit`  in  1  icache: `imemload` valid this cycle for `imemaddr`.
- `imemload`  in  32  icache read data.
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  instruction address, always equals `pc`.
- `instr`  out  32  latched instruction to control unit.
- `instr_valid`  out  1  `instr` is the current instruction under execution.
- `pc`  out  32  current PC.
- `npc`  out  32  `pc + 4`, used as the JAL link value.
- `PCsrc`  in  3  next-PC select from control unit.
- `addr`  in  26  J/JAL target field.
- `imm`  in  16  branch offset.
- `zero`  in  1  ALU zero flag from the `rs - rt` compare.
- `rdat1`  in  32  register `rs` value, used as the JR target.
- `advance`  in  1  datapath: current instruction has completed, after `dhit` for memory ops.
- `halt`  in  1  control unit decoded HALT.
- `halted`  out  1  core stopped; sticky until reset.

## Operation
- State machine with states FETCH, EXEC and HALTED.
- **FETCH:** `imemREN=1`, `instr_valid=0`. On `ihit`: `instr <= imemload`, go to EXEC. Without `ihit`, stay in FETCH with `pc` held.
- **EXEC:** `imemREN=0`, `instr_valid=1`, `instr` held stable.
  - If `halt`: go to HALTED, `pc` unchanged.
  - Else if `advance`: `pc <= next_pc`, go to FETCH.
  - Otherwise hold.
  - `halt` has priority over a simultaneous `advance`.
- **HALTED:** `imemREN=0`, `instr_valid=0`, `halted=1`. All inputs are ignored; only `RST` exits.
- `next_pc` is combinational, with `b = pc + 4 + (sext(imm) << 2)`:
  - `PCsrc` 0 → `pc+4`.
  - 2 → `rdat1`.
  - 3 → `{npc[31:28], addr, 2'b00}`.
  - 4 (BNE) → `zero ? pc+4 : b`.
  - 5 (BEQ) → `zero ? b : pc+4`.
  - 1, 6, 7 → `pc+4`.
- Every `next_pc` result has bits [1:0] forced to `2'b00` before loading.
- Arithmetic rules:
  - All adds are 32-bit and wrap modulo 2^32, with no overflow detection; `pc=32'hFFFF_FFFC` gives `pc+4 = 0`.
  - `sext` replicates `imm[15]` into bits [31:16] before the 2-bit shift.
- `ihit` outside FETCH is ignored. `advance` outside EXEC is ignored.
- **Reset** (any state, including mid-fetch with `ihit` high): next cycle
  - state = FETCH, `pc = PC_INIT` (low bits forced 00), `instr = 0`;
  - outputs `imemREN=1`, `instr_valid=0`, `halted=0`, `imemaddr=PC_INIT`, `npc=PC_INIT+4`.

## Timing
- Fetch latency: `instr` is valid the cycle after the first cycle in which `ihit` is high during FETCH. Minimum 1 cycle in FETCH.
- Minimum instruction period: 2 cycles (FETCH with `ihit` at once, then EXEC with `advance` at once).
- `pc` updates on the edge that leaves EXEC. The new `imemaddr` appears in the following FETCH cycle.
- `npc`, `imemaddr` and `instr_valid` are registered-state-derived only, with no combinational path from inputs.
- `next_pc` has a combinational path from `PCsrc`, `zero`, `rdat1`, `imm` and `addr`, but it is sampled only at the EXEC→FETCH edge.
- `halted` asserts the cycle after the EXEC cycle in which `halt` is seen.

## Test plan
- **Reset/sequential:** `PC_INIT=0`; release `RST`; `ihit` on the 3rd FETCH cycle with `imemload=32'h2001_0005`.
  - Required: `imemaddr=0` throughout the wait; `instr` equals that word one cycle later with `instr_valid=1`.
  - `advance` → `pc=4`, `imemREN=1`.
- **BEQ taken/not taken:** `pc=32'h100`, `PCsrc=5`, `imm=16'hFFFE`.
  - `zero=1` → `pc=32'h0FC`.
  - `zero=0` → `pc=32'h104`.
  - BNE (`PCsrc=4`) gives the inverse results.
- **J/JR:**
  - `pc=32'h1000_0040`, `PCsrc=3`, `addr=26'h000_0010` → `pc=32'h1000_0040`.
  - `PCsrc=2`, `rdat1=32'h0000_0123` → `pc=32'h0000_0120`.
  - `npc=32'h1000_0044` before the jump.
- **Halt priority:** `halt=1` and `advance=1` in the same EXEC cycle → `halted=1` next cycle and `pc` unchanged. Later `ihit` and `advance` pulses cause no change.
- **Wrap and reset mid-operation:**
  - `pc=32'hFFFF_FFFC`, `PCsrc=0`, `advance` → `pc=0`.
  - Assert `RST` during FETCH with `ihit=1` → `instr=0`, `pc=PC_INIT`, `instr_valid=0` next cycle.
- **Stall hold:** hold `advance=0` for 10 EXEC cycles while toggling `imemload` and `ihit` → `instr`, `pc` and `imemREN=0` stay constant.
